// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for fwd_scoreboard: issue info, source lookups, per-stage results
// and the forwarded operands / stall coming back.
interface fwd_scoreboard_if #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5
);
  logic                         flush;
  logic                         issue_valid;
  logic                         issue_we;
  logic [ADDR_W-1:0]            issue_waddr;
  logic                         issue_is_load;
  logic [ADDR_W-1:0]            rs_addr;
  logic [ADDR_W-1:0]            rt_addr;
  logic [DATA_W-1:0]            rs_data_in;
  logic [DATA_W-1:0]            rt_data_in;
  logic [NUM_STAGES*DATA_W-1:0] stage_data;
  logic [DATA_W-1:0]            rs_data;
  logic [DATA_W-1:0]            rt_data;
  logic                         rs_fwd_hit;
  logic                         rt_fwd_hit;
  logic                         stall;
  logic [NUM_STAGES-1:0]        stage_live;

  modport master (
    output flush, issue_valid, issue_we, issue_waddr, issue_is_load,
    output rs_addr, rt_addr, rs_data_in, rt_data_in, stage_data,
    input  rs_data, rt_data, rs_fwd_hit, rt_fwd_hit, stall, stage_live
  );

  modport slave (
    input  flush, issue_valid, issue_we, issue_waddr, issue_is_load,
    input  rs_addr, rt_addr, rs_data_in, rt_data_in, stage_data,
    output rs_data, rt_data, rs_fwd_hit, rt_fwd_hit, stall, stage_live
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight register writes, forwards operands, stalls on
// not-yet-ready loads. Define FWD_SCOREBOARD_STATS_EN to add stall/forward counters.
module fwd_scoreboard #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  fwd_scoreboard_if.slave bus
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]     stall_cycles,
  output logic [15:0]     fwd_count
`endif
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] we_q;
  logic [NUM_STAGES-1:0] is_load_q;
  logic [ADDR_W-1:0]     waddr_q [NUM_STAGES];

  logic [NUM_STAGES-1:0] ready;
  logic [DATA_W-1:0]     rs_val, rt_val;
  logic                  rs_hit, rt_hit;
  logic                  rs_blocked, rt_blocked;
  logic                  stall_c;
  logic                  accept;

  always_comb begin
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      ready[k] = ~is_load_q[k] | (k >= int'(LOAD_LAT));
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    rs_val     = bus.rs_data_in;
    rt_val     = bus.rt_data_in;
    rs_hit     = 1'b0;
    rt_hit     = 1'b0;
    rs_blocked = 1'b0;
    rt_blocked = 1'b0;
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && (waddr_q[k] == bus.rs_addr) && (bus.rs_addr != '0)) begin
        rs_hit     = ready[k];
        rs_blocked = ~ready[k];
        rs_val     = ready[k] ? bus.stage_data[k*DATA_W +: DATA_W] : bus.rs_data_in;
      end
      if (valid_q[k] && we_q[k] && (waddr_q[k] == bus.rt_addr) && (bus.rt_addr != '0)) begin
        rt_hit     = ready[k];
        rt_blocked = ~ready[k];
        rt_val     = ready[k] ? bus.stage_data[k*DATA_W +: DATA_W] : bus.rt_data_in;
      end
    end
  end

  assign stall_c = bus.issue_valid & ~bus.flush & (rs_blocked | rt_blocked);
  assign accept  = bus.issue_valid & ~bus.flush & ~stall_c;

  assign bus.rs_data    = rs_val;
  assign bus.rt_data    = rt_val;
  assign bus.rs_fwd_hit = rs_hit;
  assign bus.rt_fwd_hit = rt_hit;
  assign bus.stall      = stall_c;
  assign bus.stage_live = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      we_q      <= '0;
      is_load_q <= '0;
      for (int k = 0; k < int'(NUM_STAGES); k++) waddr_q[k] <= '0;
    end else if (bus.flush) begin
      valid_q   <= '0;
      we_q      <= '0;
      is_load_q <= '0;
      for (int k = 0; k < int'(NUM_STAGES); k++) waddr_q[k] <= '0;
    end else begin
      for (int k = int'(NUM_STAGES) - 1; k > 0; k--) begin
        valid_q[k]   <= valid_q[k-1];
        we_q[k]      <= we_q[k-1];
        is_load_q[k] <= is_load_q[k-1];
        waddr_q[k]   <= waddr_q[k-1];
      end
      // A stalled or idle decode slot enters the pipe as a bubble.
      valid_q[0]   <= accept;
      we_q[0]      <= accept & bus.issue_we & (bus.issue_waddr != '0);
      is_load_q[0] <= accept & bus.issue_is_load;
      waddr_q[0]   <= accept ? bus.issue_waddr : '0;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      fwd_count    <= '0;
    end else begin
      if (stall_c && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (accept && (rs_hit || rt_hit) && (fwd_count != 16'hFFFF)) begin
        fwd_count <= fwd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed test-plan steps plus random traffic on a
// default (2-stage, LOAD_LAT=1) and a 3-stage LOAD_LAT=2 instance against a queue-style model.
module tb_fwd_scoreboard;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wa;
    logic       ld;
  } rec_t;
  typedef rec_t [3:0] pipe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  pipe_t pa = '0;
  pipe_t pb = '0;
  logic [31:0] oa_rs, oa_rt, ob_rt;
  logic        oa_stall, ob_stall, oa_rsh;
  logic [1:0]  oa_live;

  fwd_scoreboard_if #(.NUM_STAGES(2), .DATA_W(32), .ADDR_W(5)) ia ();
  fwd_scoreboard_if #(.NUM_STAGES(3), .DATA_W(32), .ADDR_W(5)) ib ();

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
`endif

  fwd_scoreboard #(.NUM_STAGES(2), .LOAD_LAT(1), .DATA_W(32), .ADDR_W(5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stall_cycles (sc_a),
    .fwd_count    (fc_a)
`endif
  );

  fwd_scoreboard #(.NUM_STAGES(3), .LOAD_LAT(2), .DATA_W(32), .ADDR_W(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stall_cycles (sc_b),
    .fwd_count    (fc_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {blocked, hit, data}: youngest writer of src decides the outcome.
  function automatic logic [33:0] predict(input pipe_t p, input int n, input int ll,
                                          input logic [4:0] src, input logic [31:0] rf,
                                          input logic [127:0] sd);
    for (int k = 0; k < n; k++) begin
      if (p[k].v && p[k].we && p[k].wa == src && src != 5'd0) begin
        if (!p[k].ld || k >= ll) return {1'b0, 1'b1, sd[k*32 +: 32]};
        return {1'b1, 1'b0, rf};
      end
    end
    return {2'b00, rf};
  endfunction

  function automatic pipe_t advance(input pipe_t p, input logic clr, input logic acc,
                                    input logic we, input logic [4:0] wa, input logic ld);
    pipe_t nx;
    if (clr) return '0;
    for (int k = 3; k > 0; k--) nx[k] = p[k-1];
    nx[0] = acc ? {1'b1, we && (wa != 5'd0), wa, ld} : 8'h00;
    return nx;
  endfunction

  function automatic logic [3:0] live(input pipe_t p, input int n);
    logic [3:0] l = '0;
    for (int k = 0; k < n; k++) l[k] = p[k].v;
    return l;
  endfunction

  task automatic tick();
    logic [33:0] ra, ta, rb, tb2;
    logic sa, sb;
    @(negedge clk);
    ra = predict(pa, 2, 1, ia.rs_addr, ia.rs_data_in, {64'h0, ia.stage_data});
    ta = predict(pa, 2, 1, ia.rt_addr, ia.rt_data_in, {64'h0, ia.stage_data});
    sa = ia.issue_valid & ~ia.flush & (ra[33] | ta[33]);
    chk("a_stall", ia.stall, sa);
    chk("a_rs_hit", ia.rs_fwd_hit, ra[32]);
    chk("a_rt_hit", ia.rt_fwd_hit, ta[32]);
    if (!ra[33]) chk("a_rs_data", ia.rs_data, ra[31:0]);
    if (!ta[33]) chk("a_rt_data", ia.rt_data, ta[31:0]);
    chk("a_live", ia.stage_live, live(pa, 2));
    rb  = predict(pb, 3, 2, ib.rs_addr, ib.rs_data_in, {32'h0, ib.stage_data});
    tb2 = predict(pb, 3, 2, ib.rt_addr, ib.rt_data_in, {32'h0, ib.stage_data});
    sb = ib.issue_valid & ~ib.flush & (rb[33] | tb2[33]);
    chk("b_stall", ib.stall, sb);
    chk("b_rs_hit", ib.rs_fwd_hit, rb[32]);
    chk("b_rt_hit", ib.rt_fwd_hit, tb2[32]);
    if (!rb[33]) chk("b_rs_data", ib.rs_data, rb[31:0]);
    if (!tb2[33]) chk("b_rt_data", ib.rt_data, tb2[31:0]);
    chk("b_live", ib.stage_live, live(pb, 3));
    oa_rs = ia.rs_data;  oa_rt = ia.rt_data;  oa_stall = ia.stall;
    oa_rsh = ia.rs_fwd_hit;  oa_live = ia.stage_live;
    ob_rt = ib.rt_data;  ob_stall = ib.stall;
    @(posedge clk);
    pa = advance(pa, rst | ia.flush, ia.issue_valid & ~sa, ia.issue_we, ia.issue_waddr,
                 ia.issue_is_load);
    pb = advance(pb, rst | ib.flush, ib.issue_valid & ~sb, ib.issue_we, ib.issue_waddr,
                 ib.issue_is_load);
    #1;
  endtask

  task automatic drv_a(input logic iv, input logic we, input logic [4:0] wa, input logic ld,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl);
    ia.issue_valid = iv;  ia.issue_we = we;  ia.issue_waddr = wa;  ia.issue_is_load = ld;
    ia.rs_addr = rs;  ia.rt_addr = rt;  ia.flush = fl;
    ia.rs_data_in = $urandom;  ia.rt_data_in = $urandom;
    ia.stage_data = {$urandom, $urandom};
  endtask

  task automatic drv_b(input logic iv, input logic we, input logic [4:0] wa, input logic ld,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl);
    ib.issue_valid = iv;  ib.issue_we = we;  ib.issue_waddr = wa;  ib.issue_is_load = ld;
    ib.rs_addr = rs;  ib.rt_addr = rt;  ib.flush = fl;
    ib.rs_data_in = $urandom;  ib.rt_data_in = $urandom;
    ib.stage_data = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    drv_a(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    drv_b(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    tick();
    drv_a(1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 1'b0);
    tick();
    chk("rst_rs_pass", oa_rs, ia.rs_data_in);
    chk("rst_stall", oa_stall, 1'b0);
    chk("rst_live", oa_live, 2'b00);
    rst = 1'b0;

    // ALU back-to-back
    drv_a(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0);
    ia.stage_data[31:0] = 32'h0000_0010;
    tick();
    chk("alu_b2b_data", oa_rs, 32'h10);
    chk("alu_b2b_hit", oa_rsh, 1'b1);
    chk("alu_b2b_stall", oa_stall, 1'b0);

    // Youngest producer wins
    drv_a(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b0);
    ia.stage_data = {32'hAAAA_AAAA, 32'h5555_5555};
    tick();
    chk("youngest", oa_rt, 32'h5555_5555);

    // rs == rt
    drv_a(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6, 1'b0);
    tick();
    chk("rs_eq_rt_rs", oa_rs, ia.stage_data[31:0]);
    chk("rs_eq_rt_rt", oa_rt, ia.stage_data[31:0]);

    // Load-use, LOAD_LAT=1
    drv_a(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    drv_a(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 1'b0);
    tick();
    chk("lu_a_stall", oa_stall, 1'b1);
    ia.stage_data[63:32] = 32'hDEAD_BEEF;
    tick();
    chk("lu_a_fwd", oa_rs, 32'hDEAD_BEEF);
    chk("lu_a_nostall", oa_stall, 1'b0);
    chk("lu_a_live", oa_live, 2'b10);

    // Load-use, LOAD_LAT=2 with 3 stages
    drv_a(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    drv_b(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv_b(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b0);
    tick();
    chk("lu_b_stall1", ob_stall, 1'b1);
    tick();
    chk("lu_b_stall2", ob_stall, 1'b1);
    ib.stage_data[95:64] = 32'hCAFE_F00D;
    tick();
    chk("lu_b_fwd", ob_rt, 32'hCAFE_F00D);
    chk("lu_b_nostall", ob_stall, 1'b0);
    drv_b(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);

    // Writes to $0 never forward
    drv_a(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    ia.rs_data_in = 32'h0;
    tick();
    chk("zero_hit", oa_rsh, 1'b0);
    chk("zero_stall", oa_stall, 1'b0);
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    ia.rs_data_in = 32'h0;
    tick();
    chk("zero_data", oa_rs, 32'h0);
    chk("zero_hit2", oa_rsh, 1'b0);

    // Flush with a load in stage 0
    drv_a(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1);
    tick();
    chk("flush_stall", oa_stall, 1'b0);
    drv_a(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("flush_live", oa_live, 2'b00);

    // Asynchronous reset in the middle of a stall
    drv_a(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drv_a(1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 1'b0);
    @(negedge clk);
    chk("arst_pre_stall", ia.stall, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", ia.stall, 1'b0);
    chk("arst_live", ia.stage_live, 2'b00);
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("arst_stall_cycles", sc_a, 16'h0);
`endif
    @(posedge clk);
    #1;
    pa = '0;
    pb = '0;
    rst = 1'b0;

    // Random traffic on both instances
    repeat (400) begin
      drv_a(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            ($urandom_range(0, 19) == 0));
      drv_b(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
